// File: rtl/neureka_package.sv
// Shared constants and types for the NEUREKA accelerator.
// Holds the wide-port bandwidth, the TCDM arbiter outstanding-read depth and the
// 1-bit requester id used to tag reads with their issuer.
package neureka_package;

  localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 256;
  localparam int unsigned NEUREKA_TCDM_ARB_OUTST    = 4;

  // 0 = data streamer, 1 = weight streamer
  typedef logic tcdm_arb_id_t;

endpackage

// File: rtl/neureka_tcdm_arb_owner_fifo.sv
// Owner FIFO for the TCDM arbiter: remembers which requester issued each
// outstanding read so in-order responses can be routed back.
// Ports:
//   clk_i, rst_ni, clear_i : clock, async active-low reset, sync clear
//   push_i, push_id_i      : enqueue the id of a granted read
//   pop_i                  : dequeue on a read response
//   full_o, empty_o        : occupancy flags
//   head_o                 : id of the oldest outstanding read
module neureka_tcdm_arb_owner_fifo
  import neureka_package::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  tcdm_arb_id_t push_id_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output tcdm_arb_id_t head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  tcdm_arb_id_t [Depth-1:0] mem_q;
  logic [PtrW-1:0]          wptr_q, rptr_q;
  logic [CntW-1:0]          cnt_q, cnt_d;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  // Simultaneous push and pop leave the count unchanged, even when full.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push_i && pop_i) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_id_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/neureka_tcdm_arbiter.sv
// Round-robin arbiter sharing the wide TCDM master port between the data
// streamer (requester 0) and the weight streamer (requester 1). The request
// path is combinational; read owners are queued so responses return to issuer.
// Ports:
//   in_*   : per-requester request/grant/response (index 0 data, 1 weight)
//   out_*  : shared TCDM port towards the port splitter
//   busy_o : reads outstanding or any request pending
//   err_o  : sticky, a response arrived with no outstanding read
module neureka_tcdm_arbiter
  import neureka_package::*;
#(
  parameter int unsigned BW        = NEUREKA_MEM_BANDWIDTH_EXT,
  parameter int unsigned MAX_OUTST = NEUREKA_TCDM_ARB_OUTST
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [1:0]               in_req_i,
  output logic [1:0]               in_gnt_o,
  input  logic [1:0][31:0]         in_add_i,
  input  logic [1:0]               in_wen_i,
  input  logic [1:0][BW/8-1:0]     in_be_i,
  input  logic [1:0][BW-1:0]       in_data_i,
  output logic [1:0][BW-1:0]       in_r_data_o,
  output logic [1:0]               in_r_valid_o,
  output logic                     out_req_o,
  input  logic                     out_gnt_i,
  output logic [31:0]              out_add_o,
  output logic                     out_wen_o,
  output logic [BW/8-1:0]          out_be_o,
  output logic [BW-1:0]            out_data_o,
  input  logic [BW-1:0]            out_r_data_i,
  input  logic                     out_r_valid_i,
  output logic                     busy_o,
  output logic                     err_o
);

  tcdm_arb_id_t rr_ptr_q, rr_ptr_d;
  tcdm_arb_id_t lock_id_q, lock_id_d;
  logic         locked_q, locked_d;
  logic         err_q, err_d;
  tcdm_arb_id_t winner, head;
  logic         win_req, win_read, block, hs;
  logic         fifo_full, fifo_empty, push, pop;

  // A stalled winner keeps the port until granted or until it withdraws.
  always_comb begin
    winner = tcdm_arb_id_t'(1'b0);
    if (locked_q && in_req_i[lock_id_q]) begin
      winner = lock_id_q;
    end else if (in_req_i == 2'b10) begin
      winner = tcdm_arb_id_t'(1'b1);
    end else if (in_req_i == 2'b11) begin
      winner = rr_ptr_q;
    end
  end

  assign win_req  = in_req_i[winner];
  assign win_read = in_wen_i[winner];
  // A pop in the same cycle frees a slot, so a full FIFO need not stall.
  assign block    = win_read && fifo_full && !out_r_valid_i;
  assign hs       = out_req_o && out_gnt_i;
  assign push     = hs && win_read;
  assign pop      = out_r_valid_i && !fifo_empty;

  assign out_req_o  = win_req && !block;
  assign out_add_o  = win_req ? in_add_i[winner]  : '0;
  assign out_wen_o  = win_req && win_read;
  assign out_be_o   = win_req ? in_be_i[winner]   : '0;
  assign out_data_o = win_req ? in_data_i[winner] : '0;

  always_comb begin
    in_gnt_o             = '0;
    in_gnt_o[winner]     = hs;
    in_r_valid_o         = '0;
    in_r_valid_o[head]   = pop;
    in_r_data_o[0]       = out_r_data_i;
    in_r_data_o[1]       = out_r_data_i;
  end

  assign busy_o = !fifo_empty || (|in_req_i);
  assign err_o  = err_q;

  always_comb begin
    rr_ptr_d  = hs ? ~winner : rr_ptr_q;
    locked_d  = win_req && !hs;
    lock_id_d = win_req && !hs ? winner : lock_id_q;
    err_d     = err_q || (out_r_valid_i && fifo_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      locked_q  <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else if (clear_i) begin
      rr_ptr_q  <= '0;
      locked_q  <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      locked_q  <= locked_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  neureka_tcdm_arb_owner_fifo #(
    .Depth (MAX_OUTST)
  ) i_owner_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .push_i    (push),
    .push_id_i (winner),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head)
  );

endmodule

// File: tb/tb_neureka_tcdm_arbiter.sv
module tb_neureka_tcdm_arbiter;

  localparam int unsigned BW = 64;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 clear_i;
  logic [1:0]           in_req_i;
  logic [1:0]           in_gnt_o;
  logic [1:0][31:0]     in_add_i;
  logic [1:0]           in_wen_i;
  logic [1:0][BW/8-1:0] in_be_i;
  logic [1:0][BW-1:0]   in_data_i;
  logic [1:0][BW-1:0]   in_r_data_o;
  logic [1:0]           in_r_valid_o;
  logic                 out_req_o;
  logic                 out_gnt_i;
  logic [31:0]          out_add_o;
  logic                 out_wen_o;
  logic [BW/8-1:0]      out_be_o;
  logic [BW-1:0]        out_data_o;
  logic [BW-1:0]        out_r_data_i;
  logic                 out_r_valid_i;
  logic                 busy_o;
  logic                 err_o;

  int n_vec = 0;
  int n_err = 0;

  neureka_tcdm_arbiter #(
    .BW        (BW),
    .MAX_OUTST (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .in_req_i      (in_req_i),
    .in_gnt_o      (in_gnt_o),
    .in_add_i      (in_add_i),
    .in_wen_i      (in_wen_i),
    .in_be_i       (in_be_i),
    .in_data_i     (in_data_i),
    .in_r_data_o   (in_r_data_o),
    .in_r_valid_o  (in_r_valid_o),
    .out_req_o     (out_req_o),
    .out_gnt_i     (out_gnt_i),
    .out_add_o     (out_add_o),
    .out_wen_o     (out_wen_o),
    .out_be_o      (out_be_o),
    .out_data_o    (out_data_o),
    .out_r_data_i  (out_r_data_i),
    .out_r_valid_i (out_r_valid_i),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out_req"}, 64'(out_req_o), 64'd0);
    chk({tag, ".gnt"}, 64'(in_gnt_o), 64'd0);
    chk({tag, ".add"}, 64'(out_add_o), 64'd0);
    chk({tag, ".data"}, out_data_o, 64'd0);
    chk({tag, ".rvalid"}, 64'(in_r_valid_o), 64'd0);
    chk({tag, ".busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst_ni        = 1'b0;
    clear_i       = 1'b0;
    in_req_i      = '0;
    in_add_i[0]   = 32'h100;
    in_add_i[1]   = 32'h300;
    in_wen_i      = 2'b11;
    in_be_i[0]    = 8'h0F;
    in_be_i[1]    = 8'hF0;
    in_data_i[0]  = 64'h1111_2222_3333_4444;
    in_data_i[1]  = 64'h5555_6666_7777_8888;
    out_gnt_i     = 1'b0;
    out_r_data_i  = '0;
    out_r_valid_i = 1'b0;
    #2;
    chk_idle("reset");
    chk("reset.err", 64'(err_o), 64'd0);
    #10;
    rst_ni = 1'b1;
    step();

    // 1: lone read on requester 0, response one cycle later
    in_req_i = 2'b01; out_gnt_i = 1'b1; #1;
    chk("t1.add", 64'(out_add_o), 64'h100);
    chk("t1.gnt", 64'(in_gnt_o), 64'b01);
    chk("t1.wen", 64'(out_wen_o), 64'd1);
    chk("t1.be", 64'(out_be_o), 64'h0F);
    step();
    in_req_i = 2'b00; out_r_valid_i = 1'b1; out_r_data_i = 64'hA5A5_A5A5_A5A5_A5A5; #1;
    chk("t1.rvalid", 64'(in_r_valid_o), 64'b01);
    chk("t1.rdata", in_r_data_o[0], 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t1.busy", 64'(busy_o), 64'd1);
    step();
    out_r_valid_i = 1'b0; #1;
    chk("t1.idle", 64'(busy_o), 64'd0);

    // rr_ptr is now 1; a lone write from requester 1 brings it back to 0
    in_req_i = 2'b10; in_wen_i = 2'b00; #1;
    chk("wr1.gnt", 64'(in_gnt_o), 64'b10);
    chk("wr1.wen", 64'(out_wen_o), 64'd0);
    chk("wr1.data", out_data_o, 64'h5555_6666_7777_8888);
    step();

    // 2: contention, four granted reads alternate 0,1,0,1
    in_req_i = 2'b11; in_wen_i = 2'b11; in_add_i[0] = 32'h200; #1;
    chk("t2.c0.gnt", 64'(in_gnt_o), 64'b01);
    chk("t2.c0.add", 64'(out_add_o), 64'h200);
    step();
    chk("t2.c1.gnt", 64'(in_gnt_o), 64'b10);
    chk("t2.c1.add", 64'(out_add_o), 64'h300);
    step();
    chk("t2.c2.gnt", 64'(in_gnt_o), 64'b01);
    chk("t2.c2.add", 64'(out_add_o), 64'h200);
    step();
    chk("t2.c3.gnt", 64'(in_gnt_o), 64'b10);
    chk("t2.c3.add", 64'(out_add_o), 64'h300);
    step();
    in_req_i = 2'b00; out_r_valid_i = 1'b1;
    out_r_data_i = 64'd10; #1; chk("t2.r0", 64'(in_r_valid_o), 64'b01);
    step(); out_r_data_i = 64'd11; #1; chk("t2.r1", 64'(in_r_valid_o), 64'b10);
    chk("t2.r1.data", in_r_data_o[1], 64'd11);
    step(); chk("t2.r2", 64'(in_r_valid_o), 64'b01);
    step(); chk("t2.r3", 64'(in_r_valid_o), 64'b10);
    step();
    out_r_valid_i = 1'b0; #1;
    chk("t2.busy", 64'(busy_o), 64'd0);
    chk("t2.err", 64'(err_o), 64'd0);

    // Lock: stalled requester 0 keeps the port even though rr_ptr points at 1
    in_wen_i = 2'b00; in_add_i[0] = 32'h400; in_add_i[1] = 32'h500;
    in_req_i = 2'b01; #1; chk("rr.set", 64'(in_gnt_o), 64'b01);
    step();
    out_gnt_i = 1'b0; #1;
    chk("lock.req", 64'(out_req_o), 64'd1);
    chk("lock.gnt0", 64'(in_gnt_o), 64'b00);
    step();
    in_req_i = 2'b11; #1;
    chk("lock.hold", 64'(out_add_o), 64'h400);
    step();
    out_gnt_i = 1'b1; #1;
    chk("lock.gnt", 64'(in_gnt_o), 64'b01);
    step();

    // 3: stall with rr_ptr=1, requester 1 held for three cycles
    out_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3.add", 64'(out_add_o), 64'h500);
      chk("t3.gnt", 64'(in_gnt_o), 64'b00);
      step();
    end
    out_gnt_i = 1'b1; #1;
    chk("t3.grant", 64'(in_gnt_o), 64'b10);
    step();
    out_gnt_i = 1'b0; #1;
    chk("t3.rr0", 64'(out_add_o), 64'h400);
    in_req_i = 2'b00;
    step();

    // 4: fill owner FIFO with four reads from requester 0
    in_wen_i = 2'b11; in_req_i = 2'b01; out_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4.fill", 64'(in_gnt_o), 64'b01);
      step();
    end
    chk("t4.blk.req", 64'(out_req_o), 64'd0);
    chk("t4.blk.gnt", 64'(in_gnt_o), 64'b00);
    chk("t4.blk.busy", 64'(busy_o), 64'd1);
    out_r_valid_i = 1'b1; #1;
    chk("t4.pp.req", 64'(out_req_o), 64'd1);
    chk("t4.pp.gnt", 64'(in_gnt_o), 64'b01);
    chk("t4.pp.rv", 64'(in_r_valid_o), 64'b01);
    step();
    out_r_valid_i = 1'b0; #1;
    chk("t4.still.full", 64'(out_req_o), 64'd0);
    in_wen_i = 2'b00; #1;
    chk("t4.wr.gnt", 64'(in_gnt_o), 64'b01);
    step();
    in_req_i = 2'b00; out_r_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4.drain", 64'(in_r_valid_o), 64'b01);
      step();
    end
    out_r_valid_i = 1'b0; #1;
    chk("t4.empty", 64'(busy_o), 64'd0);
    chk("t4.err", 64'(err_o), 64'd0);

    // 5: stray response
    out_r_valid_i = 1'b1; #1;
    chk("t5.rv", 64'(in_r_valid_o), 64'b00);
    step();
    out_r_valid_i = 1'b0; #1;
    chk("t5.err", 64'(err_o), 64'd1);
    step();
    chk("t5.hold", 64'(err_o), 64'd1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0; #1;
    chk("t5.clr", 64'(err_o), 64'd0);

    // 6: reset with two reads outstanding
    in_wen_i = 2'b11; in_req_i = 2'b01;
    step(); step();
    in_req_i = 2'b00; #1;
    chk("t6.busy", 64'(busy_o), 64'd1);
    rst_ni = 1'b0; #1;
    chk_idle("t6.rst");
    step();
    rst_ni = 1'b1; #1;
    chk_idle("t6.post");
    out_r_valid_i = 1'b1; #1;
    chk("t6.stray.rv", 64'(in_r_valid_o), 64'b00);
    step();
    out_r_valid_i = 1'b0; #1;
    chk("t6.stray.err", 64'(err_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
